// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, parity modes and the parity helper.
// Used by the transmitter and reused by the receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    localparam int unsigned MAX_DATA_BITS = 9;

    // Mode 2'b11 is deliberately treated as "no parity".
    function automatic logic parity_enabled(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

    // Callers zero-extend narrower words; the extra zeros do not change the XOR.
    function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] data,
                                         input logic [1:0]               mode);
        return (mode == PAR_ODD) ? ~(^data) : (^data);
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous show-ahead FIFO with push/pop, full/empty/count and async active-low reset.
module uart_tx_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4
) (
    input  logic                     i_Clock,
    input  logic                     i_Rst_n,
    input  logic                     i_Push,
    input  logic [WIDTH-1:0]         i_Push_Data,
    input  logic                     i_Pop,
    output logic [WIDTH-1:0]         o_Pop_Data,
    output logic                     o_Full,
    output logic                     o_Empty,
    output logic [$clog2(DEPTH):0]   o_Count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign o_Full     = (count == (PTR_W+1)'(DEPTH));
    assign o_Empty    = (count == '0);
    assign o_Count    = count;
    assign o_Pop_Data = mem[rd_ptr];

    assign do_push = i_Push & ~o_Full;
    assign do_pop  = i_Pop & ~o_Empty;

    always_ff @(posedge i_Clock) begin
        if (do_push) begin
            mem[wr_ptr] <= i_Push_Data;
        end
    end

    // Pointers are power-of-two sized, so they wrap without explicit compare.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: DATA_BITS data, runtime parity (none/even/odd), 1 or 2 stops.
// Define UART_TX_FIFO_EN to put a FIFO_DEPTH-entry FIFO in front for gapless frames.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 i_Clock,
    input  logic                 i_Rst_n,
    input  logic                 i_Tx_Valid,
    input  logic [DATA_BITS-1:0] i_Tx_Data,
    input  logic [1:0]           i_Parity_Mode,
    input  logic                 i_Stop2,
    output logic                 o_Tx_Ready,
    output logic                 o_Tx_Serial,
    output logic                 o_Tx_Active,
    output logic                 o_Tx_Done
);

    localparam int TMR_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);

    if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
        $error("uart_tx_frame: illegal parameter value");
    end

    uart_state_t          state;
    logic [TMR_W-1:0]     timer;
    logic [IDX_W-1:0]     bit_idx;
    logic [IDX_W-1:0]     next_idx;
    logic                 stop_cnt;
    logic [DATA_BITS-1:0] tx_data;
    logic [1:0]           tx_mode;
    logic                 tx_stop2;

    logic                 bit_end;
    logic                 last_stop;
    logic                 load;
    logic [DATA_BITS-1:0] ld_data;
    logic [1:0]           ld_mode;
    logic                 ld_stop2;

    assign bit_end   = (timer == TMR_W'(CLKS_PER_BIT - 1));
    assign last_stop = (state == STOP) && bit_end && (!tx_stop2 || stop_cnt);
    assign next_idx  = bit_idx + 1'b1;

`ifdef UART_TX_FIFO_EN
    localparam int ENTRY_W = DATA_BITS + 3;

    logic                       fifo_push;
    logic                       fifo_pop;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic [ENTRY_W-1:0]         fifo_rd_data;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    // Popping in the last stop-bit clock lets the next start bit follow with no gap.
    assign fifo_push  = i_Tx_Valid & o_Tx_Ready;
    assign fifo_pop   = ~fifo_empty & ((state == IDLE) | last_stop);
    assign load       = fifo_pop;
    assign {ld_data, ld_mode, ld_stop2} = fifo_rd_data;
    assign o_Tx_Ready = i_Rst_n & ~fifo_full;

    uart_tx_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_Clock     (i_Clock),
        .i_Rst_n     (i_Rst_n),
        .i_Push      (fifo_push),
        .i_Push_Data ({i_Tx_Data, i_Parity_Mode, i_Stop2}),
        .i_Pop       (fifo_pop),
        .o_Pop_Data  (fifo_rd_data),
        .o_Full      (fifo_full),
        .o_Empty     (fifo_empty),
        .o_Count     (fifo_count)
    );
`else
    assign o_Tx_Ready = i_Rst_n & (state == IDLE);
    assign load       = i_Tx_Valid & o_Tx_Ready;
    assign ld_data    = i_Tx_Data;
    assign ld_mode    = i_Parity_Mode;
    assign ld_stop2   = i_Stop2;
`endif

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state       <= IDLE;
            timer       <= '0;
            bit_idx     <= '0;
            stop_cnt    <= 1'b0;
            tx_data     <= '0;
            tx_mode     <= PAR_NONE;
            tx_stop2    <= 1'b0;
            o_Tx_Serial <= 1'b1;
            o_Tx_Active <= 1'b0;
            o_Tx_Done   <= 1'b0;
        end else begin
            o_Tx_Done <= 1'b0;
            case (state)
                IDLE: begin
                    timer <= '0;
                    if (load) begin
                        tx_data     <= ld_data;
                        tx_mode     <= ld_mode;
                        tx_stop2    <= ld_stop2;
                        state       <= START;
                        o_Tx_Serial <= 1'b0;
                        o_Tx_Active <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        timer       <= '0;
                        bit_idx     <= '0;
                        state       <= DATA;
                        o_Tx_Serial <= tx_data[0];
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        timer <= '0;
                        if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
                            stop_cnt <= 1'b0;
                            if (parity_enabled(tx_mode)) begin
                                state       <= PARITY;
                                o_Tx_Serial <= calc_parity(MAX_DATA_BITS'(tx_data), tx_mode);
                            end else begin
                                state       <= STOP;
                                o_Tx_Serial <= 1'b1;
                            end
                        end else begin
                            bit_idx     <= next_idx;
                            o_Tx_Serial <= tx_data[next_idx];
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        timer       <= '0;
                        stop_cnt    <= 1'b0;
                        state       <= STOP;
                        o_Tx_Serial <= 1'b1;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        timer <= '0;
                        if (!last_stop) begin
                            stop_cnt <= 1'b1;
                        end else begin
                            o_Tx_Done <= 1'b1;
                            if (load) begin
                                tx_data     <= ld_data;
                                tx_mode     <= ld_mode;
                                tx_stop2    <= ld_stop2;
                                state       <= START;
                                o_Tx_Serial <= 1'b0;
                            end else begin
                                state       <= IDLE;
                                o_Tx_Serial <= 1'b1;
                                o_Tx_Active <= 1'b0;
                            end
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    timer       <= '0;
                    o_Tx_Serial <= 1'b1;
                    o_Tx_Active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame: frame-level model checked every cycle plus literal frames.
// Builds with or without UART_TX_FIFO_EN.
module tb_uart_tx_frame;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int LOGN  = 4096;
`ifdef UART_TX_FIFO_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       valid = 1'b0;
    logic [7:0] data = '0;
    logic [1:0] pmode = '0;
    logic       stop2 = 1'b0;
    logic       ready, ser, act, done;

    logic       valid5 = 1'b0;
    logic [4:0] data5 = '0;
    logic [1:0] pmode5 = '0;
    logic       stop2_5 = 1'b0;
    logic       ready5, ser5, act5, done5;

    always #5 clk = ~clk;

    uart_tx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .FIFO_DEPTH(DEPTH)) dut (
        .i_Clock(clk), .i_Rst_n(rst_n), .i_Tx_Valid(valid), .i_Tx_Data(data),
        .i_Parity_Mode(pmode), .i_Stop2(stop2), .o_Tx_Ready(ready),
        .o_Tx_Serial(ser), .o_Tx_Active(act), .o_Tx_Done(done)
    );

    uart_tx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(5), .FIFO_DEPTH(DEPTH)) dut5 (
        .i_Clock(clk), .i_Rst_n(rst_n), .i_Tx_Valid(valid5), .i_Tx_Data(data5),
        .i_Parity_Mode(pmode5), .i_Stop2(stop2_5), .o_Tx_Ready(ready5),
        .o_Tx_Serial(ser5), .o_Tx_Active(act5), .o_Tx_Done(done5)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic log_ser [LOGN];
    logic log_act [LOGN];
    logic log_done[LOGN];
    logic log_ser5[LOGN];
    logic log_act5[LOGN];
    logic log_done5[LOGN];

    always @(negedge clk) begin
        if (cyc < LOGN) begin
            log_ser[cyc]   = ser;
            log_act[cyc]   = act;
            log_done[cyc]  = done;
            log_ser5[cyc]  = ser5;
            log_act5[cyc]  = act5;
            log_done5[cyc] = done5;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Frame-level model: a frame is a list of bits, each held CPB clocks.
    typedef struct {
        logic [7:0] d;
        logic [1:0] m;
        logic       s2;
    } word_t;

    word_t       m_q[$];
    logic [11:0] m_fb = '0;
    int          m_len = 0;
    int          m_pos = 0;
    bit          m_busy = 0;
    bit          m_done = 0;
    int          acc_cnt = 0;

    function automatic void start_frame(input word_t w);
        logic [11:0] fb;
        int          n;
        fb = '0;
        fb[0] = 1'b0;
        for (int i = 0; i < 8; i++) fb[1+i] = w.d[i];
        n = 9;
        if (w.m == 2'b01) begin
            fb[n] = ^w.d;
            n++;
        end else if (w.m == 2'b10) begin
            fb[n] = ~(^w.d);
            n++;
        end
        fb[n] = 1'b1;
        n++;
        if (w.s2) begin
            fb[n] = 1'b1;
            n++;
        end
        m_fb   = fb;
        m_len  = n * CPB;
        m_pos  = 0;
        m_busy = 1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        word_t w;
        bit    push, pop;
        if (!rst_n) begin
            m_busy = 0;
            m_pos  = 0;
            m_done = 0;
            m_q.delete();
        end else begin
            w.d  = data;
            w.m  = pmode;
            w.s2 = stop2;
`ifdef UART_TX_FIFO_EN
            push = valid && (m_q.size() < DEPTH);
            pop  = (m_q.size() > 0) && (!m_busy || m_pos == m_len - 1);
            m_done = 0;
            if (m_busy) begin
                m_pos++;
                if (m_pos == m_len) begin
                    m_busy = 0;
                    m_done = 1;
                end
            end
            if (pop) start_frame(m_q.pop_front());
            if (push) begin
                m_q.push_back(w);
                acc_cnt++;
            end
`else
            push = 0;
            pop  = 0;
            m_done = 0;
            if (m_busy) begin
                m_pos++;
                if (m_pos == m_len) begin
                    m_busy = 0;
                    m_done = 1;
                end
            end else if (valid) begin
                start_frame(w);
                acc_cnt++;
            end
`endif
        end
    end

    always @(negedge clk) begin
        logic e_ser, e_rdy;
        e_ser = m_busy ? m_fb[m_pos / CPB] : 1'b1;
        chk("serial", ser, e_ser);
        chk("active", act, m_busy);
        chk("done", done, m_done);
        if (rst_n) begin
`ifdef UART_TX_FIFO_EN
            e_rdy = (m_q.size() < DEPTH);
`else
            e_rdy = !m_busy;
`endif
            chk("ready", ready, e_rdy);
        end
    end

    task automatic send(input logic [7:0] d, input logic [1:0] m, input logic s2, output int acc_at);
        int n0;
        bit ok;
        n0 = acc_cnt;
        ok = 0;
        acc_at = 0;
        valid = 1'b1; data = d; pmode = m; stop2 = s2;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (acc_cnt != n0) begin
                ok = 1;
                acc_at = cyc;
                break;
            end
        end
        valid = 1'b0;
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: word %0h not accepted within 2000 cycles", d);
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (!m_busy && m_q.size() == 0) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL idle_timeout: transmitter still busy after 4000 cycles");
        end
        repeat (2) @(negedge clk);
    endtask

    // bits: one character per frame bit, start bit first.
    task automatic check_frame(input string name, input int sel, input int start,
                               input string bits, input int exp_clocks);
        logic [3:0] samp;
        logic       b;
        int         actc, donec, idx;
        for (int k = 0; k < bits.len(); k++) begin
            b = (bits[k] == 8'h31);
            for (int j = 0; j < CPB; j++) begin
                idx = start + k * CPB + j;
                samp[j] = (sel != 0) ? log_ser5[idx] : log_ser[idx];
            end
            chk($sformatf("%s_bit%0d", name, k), samp, {4{b}});
        end
        actc = 0;
        donec = 0;
        for (int i = start; i < start + exp_clocks; i++) begin
            if (((sel != 0) ? log_act5[i] : log_act[i]) === 1'b1) actc++;
            if (i > start && ((sel != 0) ? log_done5[i] : log_done[i]) === 1'b1) donec++;
        end
        chk($sformatf("%s_active_clocks", name), actc, exp_clocks);
        chk($sformatf("%s_early_done", name), donec, 0);
        chk($sformatf("%s_done_pulse", name),
            (sel != 0) ? log_done5[start + exp_clocks] : log_done[start + exp_clocks], 1);
    endtask

    initial begin
        int a, s, cnt;
        repeat (3) @(negedge clk);
        chk("rst_serial", ser, 1);
        chk("rst_active", act, 0);
        chk("rst_done", done, 0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", ready, 1);

        send(8'h55, 2'b00, 1'b0, a);
        s = a + LAT;
        wait_idle();
        check_frame("w55_none", 0, s, "0101010101", 40);

        send(8'h07, 2'b01, 1'b0, a);
        s = a + LAT;
        wait_idle();
        check_frame("w07_even", 0, s, "01110000011", 44);

        send(8'h03, 2'b10, 1'b0, a);
        s = a + LAT;
        wait_idle();
        check_frame("w03_odd", 0, s, "01100000011", 44);

        send(8'h00, 2'b10, 1'b1, a);
        s = a + LAT;
        wait_idle();
        check_frame("w00_odd_stop2", 0, s, "000000000111", 48);

`ifdef UART_TX_FIFO_EN
        send(8'hA1, 2'b00, 1'b0, a);
        s = a + 1;
        send(8'hB2, 2'b00, 1'b0, a);
        send(8'hC3, 2'b00, 1'b0, a);
        send(8'hD4, 2'b00, 1'b0, a);
        send(8'hE5, 2'b00, 1'b0, a);
        chk("fifo_full_ready", ready, 0);
        wait_idle();
        check_frame("fifo_A1", 0, s, "0100001011", 40);
        check_frame("fifo_E5", 0, s + 160, "0101001111", 40);
        cnt = 0;
        for (int i = s; i < s + 200; i++) if (log_act[i] === 1'b1) cnt++;
        chk("fifo_gapless_active", cnt, 200);
        cnt = 0;
        for (int i = s; i <= s + 200; i++) if (log_done[i] === 1'b1) cnt++;
        chk("fifo_done_count", cnt, 5);
`endif

        send(8'h0F, 2'b00, 1'b0, a);
        s = a + LAT;
        repeat (s + 20 - cyc) @(negedge clk);
        chk("mid_data_serial_low", ser, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_serial", ser, 1);
        chk("async_rst_active", act, 0);
        chk("async_rst_done", done, 0);
`ifdef UART_TX_FIFO_EN
        chk("async_rst_fifo_empty", dut.u_fifo.o_Empty, 1);
`endif
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("no_resume_after_rst", ser, 1);
        send(8'h3C, 2'b00, 1'b0, a);
        s = a + LAT;
        wait_idle();
        check_frame("w3C_after_rst", 0, s, "0001111001", 40);

        chk("ready5_idle", ready5, 1);
        valid5 = 1'b1; data5 = 5'h1B; pmode5 = 2'b01; stop2_5 = 1'b0;
        a = cyc + 1;
        @(negedge clk);
        valid5 = 1'b0;
        s = a + LAT;
        repeat (40) @(negedge clk);
        check_frame("w5_1B_even", 1, s, "01101101", 32);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish within 200000 time units");
        $fatal(1, "global timeout");
    end

endmodule
